// File: rtl/ff_skid_stage_if.sv
// Handshake bundle for the skid output stage: upstream valid/ready/data,
// downstream valid/ready/data, plus the occupancy and transfer-count status.
// "slave" is the stage's view; "master" is the environment driving it.
interface ff_skid_stage_if #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [1:0]           occupancy;
    logic [CNT_WIDTH-1:0] xfer_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, xfer_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, xfer_cnt
    );
endinterface

// File: rtl/ff_skid_stage.sv
// Elastic valid/ready output stage with a 2-entry skid buffer.
// Every output (including in_ready) comes straight from a flop, so no
// combinational path runs from out_ready back to in_ready. Words are
// presented one cycle after acceptance, one word per cycle, in order.
// xfer_cnt counts completed output handshakes and wraps.
module ff_skid_stage #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    ff_skid_stage_if.slave   skid_io
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     main_q;
    logic [WIDTH-1:0]     skid_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 out_valid_q;
    logic                 in_ready_q;
    logic [1:0]           occ_q;

    logic                 in_fire;
    logic                 out_fire;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign in_fire  = skid_io.in_valid & in_ready_q;
    assign out_fire = out_valid_q & skid_io.out_ready;
    assign cnt_d    = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    assign skid_io.in_ready  = in_ready_q;
    assign skid_io.out_valid = out_valid_q;
    assign skid_io.out_data  = main_q;
    assign skid_io.occupancy = occ_q;
    assign skid_io.xfer_cnt  = cnt_q;

    // Buffer FSM: the status outputs are updated together with the state so they stay registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
        end else begin
            if (out_fire) begin
                cnt_q <= cnt_d;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_q     <= ST_BUSY;
                        main_q      <= skid_io.in_data;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        occ_q       <= 2'd1;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_q <= skid_io.in_data;
                    end else if (in_fire) begin
                        state_q    <= ST_FULL;
                        skid_q     <= skid_io.in_data;
                        in_ready_q <= 1'b0;
                        occ_q      <= 2'd2;
                    end else if (out_fire) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        occ_q       <= 2'd0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_q    <= ST_BUSY;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        occ_q      <= 2'd1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    occ_q       <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_skid_stage.sv
// Bench for ff_skid_stage: a table of per-cycle vectors with expected
// outputs, a hand-written wrap sequence and a random burst, with a
// scoreboard queue checking that every accepted word leaves once, in order.
// A second instance with a 4-bit counter shares the stimulus to show wrapping.
module tb_ff_skid_stage;

    logic       clk;
    logic       rstN;
    logic       inValid;
    logic [3:0] inData;
    logic       outReady;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] sbQ[$];

    typedef struct {
        logic       rstN;
        logic       inValid;
        logic [3:0] inData;
        logic       outReady;
        logic       expOutValid;
        logic [3:0] expOutData;
        logic       expInReady;
        logic [1:0] expOcc;
        logic [7:0] expCnt;
    } vec_t;

    vec_t vecs[22];

    ff_skid_stage_if #(.WIDTH(4), .CNT_WIDTH(8)) busMain ();
    ff_skid_stage_if #(.WIDTH(4), .CNT_WIDTH(4)) busWrap ();

    assign busMain.in_valid  = inValid;
    assign busMain.in_data   = inData;
    assign busMain.out_ready = outReady;
    assign busWrap.in_valid  = inValid;
    assign busWrap.in_data   = inData;
    assign busWrap.out_ready = outReady;

    ff_skid_stage #(.WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rstN),
        .skid_io (busMain)
    );

    ff_skid_stage #(.WIDTH(4), .CNT_WIDTH(4)) dutWrap (
        .clk     (clk),
        .rst     (rstN),
        .skid_io (busWrap)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard: mid-cycle, record handshakes that the coming edge will complete.
    always @(negedge clk) begin
        if (!rstN) begin
            sbQ.delete();
        end else begin
            if (busMain.out_valid && outReady) begin
                compared++;
                if (sbQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL sb underflow: got %0h expected no output", busMain.out_data);
                end else begin
                    logic [3:0] expWord;
                    expWord = sbQ.pop_front();
                    if (busMain.out_data !== expWord) begin
                        mismatched++;
                        $display("[TB] FAIL sb order: got %0h expected %0h", busMain.out_data, expWord);
                    end
                end
            end
            if (inValid && busMain.in_ready) begin
                sbQ.push_back(inData);
            end
        end
    end

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic iv, input logic [3:0] d, input logic ordy);
        rstN     = r;
        inValid  = iv;
        inData   = d;
        outReady = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkEq($sformatf("v%0d out_valid", idx), 32'(busMain.out_valid), 32'(v.expOutValid));
        checkEq($sformatf("v%0d out_data", idx),  32'(busMain.out_data),  32'(v.expOutData));
        checkEq($sformatf("v%0d in_ready", idx),  32'(busMain.in_ready),  32'(v.expInReady));
        checkEq($sformatf("v%0d occupancy", idx), 32'(busMain.occupancy), 32'(v.expOcc));
        checkEq($sformatf("v%0d xfer_cnt", idx),  32'(busMain.xfer_cnt),  32'(v.expCnt));
        checkEq($sformatf("v%0d wrap_cnt", idx),  32'(busWrap.xfer_cnt),  32'(v.expCnt[3:0]));
    endtask

    initial begin
        // rstN, inValid, inData, outReady | outValid, outData, inReady, occ, cnt
        vecs[0]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 2'd1, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 8'd1};
        vecs[4]  = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1, 2'd1, 8'd2};
        vecs[5]  = '{1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 1'b1, 2'd1, 8'd3};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 2'd0, 8'd4};
        vecs[7]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5, 1'b1, 2'd1, 8'd4};
        vecs[8]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 4'h5, 1'b0, 2'd2, 8'd4};
        vecs[9]  = '{1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 4'h5, 1'b0, 2'd2, 8'd4};
        vecs[10] = '{1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 4'h5, 1'b0, 2'd2, 8'd4};
        vecs[11] = '{1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 4'h6, 1'b1, 2'd1, 8'd5};
        vecs[12] = '{1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 4'h7, 1'b1, 2'd1, 8'd6};
        vecs[13] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h7, 1'b1, 2'd0, 8'd7};
        vecs[14] = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 4'h8, 1'b1, 2'd1, 8'd7};
        vecs[15] = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 4'h8, 1'b0, 2'd2, 8'd7};
        vecs[16] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h9, 1'b1, 2'd1, 8'd8};
        vecs[17] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h9, 1'b1, 2'd0, 8'd9};
        vecs[18] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5, 1'b1, 2'd1, 8'd9};
        vecs[19] = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 4'h5, 1'b0, 2'd2, 8'd9};
        vecs[20] = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 8'd0};
        vecs[21] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 8'd0};

        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = 4'h0;
        outReady = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].inValid, vecs[i].inData, vecs[i].outReady);
            checkOutput(vecs[i], i);
        end

        $display("[TB] counter wrap sequence");
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b1, 4'(i), 1'b1);
        end
        checkEq("wrap16 main cnt", 32'(busMain.xfer_cnt), 32'd16);
        checkEq("wrap16 wrap cnt", 32'(busWrap.xfer_cnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        checkEq("wrap17 main cnt", 32'(busMain.xfer_cnt), 32'd17);
        checkEq("wrap17 wrap cnt", 32'(busWrap.xfer_cnt), 32'd1);
        checkEq("wrap17 occupancy", 32'(busMain.occupancy), 32'd0);

        $display("[TB] random burst");
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 20 && busMain.occupancy != 2'd0; k++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        end
        checkEq("drain occupancy", 32'(busMain.occupancy), 32'd0);
        checkEq("drain out_valid", 32'(busMain.out_valid), 32'd0);
        checkEq("sb leftover", 32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
